// File: rtl/pc_sequencer.sv
// pc_sequencer: next-address unit for the execute stage.
// Owns the program counter, a hardware call/return stack, conditional and
// direct jumps and the MEMW hold cycles. All outputs are registered.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset (pc=RESET_ADDR, all state cleared)
//   start         synchronous load of START_ADDR (error flags kept)
//   inst_valid    opcode/operands valid this cycle
//   opcode        instruction bits [15:12]
//   imm           direct jump target
//   reg_target    register-file target value (zero-extended)
//   reg_cond      register-file condition value (zero means "jump")
//   err_clr       clears sticky error flags (a same-cycle set wins)
//   pc            current program counter (instruction BRAM address)
//   taken         last update loaded a non-sequential target
//   busy          pc held for a MEMW
//   depth         return-stack occupancy
//   overflow_err  sticky: CALL with stack full
//   underflow_err sticky: RET with stack empty
module pc_sequencer #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned STACK_DEPTH = 8,
  parameter int unsigned START_ADDR  = 3,
  parameter int unsigned RESET_ADDR  = 0,
  parameter int unsigned MEMW_WAIT   = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             inst_valid,
  input  logic [3:0]                       opcode,
  input  logic [ADDR_W-1:0]                imm,
  input  logic [DATA_W-1:0]                reg_target,
  input  logic [DATA_W-1:0]                reg_cond,
  input  logic                             err_clr,
  output logic [ADDR_W-1:0]                pc,
  output logic                             taken,
  output logic                             busy,
  output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
  output logic                             overflow_err,
  output logic                             underflow_err
);

  localparam int unsigned DepthW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned PtrW   = $clog2(STACK_DEPTH);
  // Keep the counter at least one bit wide so MEMW_WAIT=0 still elaborates.
  localparam int unsigned CntW   = (MEMW_WAIT > 0) ? $clog2(MEMW_WAIT + 1) : 1;

  localparam logic [CntW-1:0]   WaitMax = CntW'(MEMW_WAIT);
  localparam logic [DepthW-1:0] Full    = DepthW'(STACK_DEPTH);
  localparam logic [ADDR_W-1:0] StartPc = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_ADDR);

  localparam logic [3:0] OpJmpc = 4'b1000;
  localparam logic [3:0] OpJmpd = 4'b1001;
  localparam logic [3:0] OpCall = 4'b1010;
  localparam logic [3:0] OpRet  = 4'b1011;
  localparam logic [3:0] OpMemw = 4'b1101;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              taken_q, taken_d;
  logic              busy_q, busy_d;
  logic [DepthW-1:0] depth_q, depth_d;
  logic [CntW-1:0]   wcnt_q, wcnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic              push;
  logic [PtrW-1:0]   push_idx;
  logic [PtrW-1:0]   pop_idx;
  logic [ADDR_W-1:0] seq;
  logic [ADDR_W-1:0] target;

  assign seq      = pc_q + 1'b1;
  assign target   = ADDR_W'(reg_target);
  assign push_idx = depth_q[PtrW-1:0];
  assign pop_idx  = PtrW'(depth_q - 1'b1);

  always_comb begin
    pc_d    = pc_q;
    taken_d = 1'b0;
    busy_d  = busy_q;
    depth_d = depth_q;
    wcnt_d  = wcnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;

    // Clear first so that a set later in this block overrides it.
    if (err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end

    if (start) begin
      pc_d    = StartPc;
      depth_d = '0;
      wcnt_d  = '0;
      busy_d  = 1'b0;
    end else if (inst_valid) begin
      wcnt_d = '0;
      busy_d = 1'b0;
      pc_d   = seq;
      case (opcode)
        OpJmpc: begin
          if (reg_cond == '0) begin
            pc_d    = target;
            taken_d = 1'b1;
          end
        end
        OpJmpd: begin
          pc_d    = imm;
          taken_d = 1'b1;
        end
        OpCall: begin
          if (depth_q < Full) begin
            push    = 1'b1;
            depth_d = depth_q + 1'b1;
            pc_d    = target;
            taken_d = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
        OpRet: begin
          if (depth_q != '0) begin
            pc_d    = stack_q[pop_idx];
            depth_d = depth_q - 1'b1;
            taken_d = 1'b1;
          end else begin
            unf_d = 1'b1;
          end
        end
        OpMemw: begin
          if (wcnt_q < WaitMax) begin
            pc_d   = pc_q;
            wcnt_d = wcnt_q + 1'b1;
            busy_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= ResetPc;
      taken_q <= 1'b0;
      busy_q  <= 1'b0;
      depth_q <= '0;
      wcnt_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      taken_q <= taken_d;
      busy_q  <= busy_d;
      depth_q <= depth_d;
      wcnt_q  <= wcnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage needs no reset; occupancy alone defines valid entries.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      stack_q[push_idx] <= seq;
    end
  end

  assign pc            = pc_q;
  assign taken         = taken_q;
  assign busy          = busy_q;
  assign depth         = depth_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed stimulus pushes expected outputs into a
// queue; a monitor pops and compares one entry after every rising edge.
// Instance dut uses default parameters; dut_b uses MEMW_WAIT=3.
module tb_pc_sequencer;

  localparam logic [3:0] NOP  = 4'b0000;
  localparam logic [3:0] JMPC = 4'b1000;
  localparam logic [3:0] JMPD = 4'b1001;
  localparam logic [3:0] CALL = 4'b1010;
  localparam logic [3:0] RET  = 4'b1011;
  localparam logic [3:0] MEMW = 4'b1101;

  logic        clk = 1'b0;
  logic        rst, start, iv, err_clr;
  logic        rst_b, iv_b;
  logic [3:0]  opcode;
  logic [11:0] imm;
  logic [7:0]  reg_target, reg_cond;

  logic [11:0] pc_a, pc_b;
  logic        tk_a, tk_b, bz_a, bz_b, ov_a, ov_b, un_a, un_b;
  logic [3:0]  dp_a, dp_b;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .inst_valid(iv), .opcode(opcode),
    .imm(imm), .reg_target(reg_target), .reg_cond(reg_cond), .err_clr(err_clr),
    .pc(pc_a), .taken(tk_a), .busy(bz_a), .depth(dp_a),
    .overflow_err(ov_a), .underflow_err(un_a)
  );

  pc_sequencer #(.MEMW_WAIT(3)) dut_b (
    .clk(clk), .rst(rst_b), .start(1'b0), .inst_valid(iv_b), .opcode(opcode),
    .imm(imm), .reg_target(reg_target), .reg_cond(reg_cond), .err_clr(1'b0),
    .pc(pc_b), .taken(tk_b), .busy(bz_b), .depth(dp_b),
    .overflow_err(ov_b), .underflow_err(un_b)
  );

  typedef struct {
    bit          sel;
    logic [19:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: one expected entry per rising edge, sampled 1 time unit later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        logic [19:0] act;
        e = q.pop_front();
        act = e.sel ? {pc_b, tk_b, bz_b, dp_b, ov_b, un_b}
                    : {pc_a, tk_a, bz_a, dp_a, ov_a, un_a};
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s: got pc=%h tk=%b bz=%b dp=%0d ov=%b un=%b, want pc=%h tk=%b bz=%b dp=%0d ov=%b un=%b",
                   e.name, act[19:8], act[7], act[6], act[5:2], act[1], act[0],
                   e.val[19:8], e.val[7], e.val[6], e.val[5:2], e.val[1], e.val[0]);
        end
      end
    end
  end

  task automatic ins(input logic v, input logic [3:0] o, input logic [11:0] i,
                     input logic [7:0] t, input logic [7:0] c);
    iv = v; opcode = o; imm = i; reg_target = t; reg_cond = c;
  endtask

  // Push the outputs expected after the coming edge, then advance one cycle.
  task automatic tick(input bit sel, input logic [11:0] pc_e, input bit tk_e,
                      input bit bz_e, input int dp_e, input bit ov_e, input bit un_e,
                      input string nm);
    exp_t e;
    e.sel  = sel;
    e.val  = {pc_e, tk_e, bz_e, 4'(dp_e), ov_e, un_e};
    e.name = nm;
    q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; start = 0; err_clr = 0; rst_b = 1; iv_b = 0;
    ins(0, NOP, 12'h000, 8'h00, 8'h00);
    @(negedge clk);

    // 1. reset, sequential run, start
    tick(0, 12'h000, 0, 0, 0, 0, 0, "reset0");
    tick(0, 12'h000, 0, 0, 0, 0, 0, "reset1");
    rst = 0; rst_b = 0;
    ins(1, NOP, 12'h000, 8'h00, 8'h00);
    for (int k = 1; k <= 5; k++) tick(0, 12'(k), 0, 0, 0, 0, 0, "seq");
    start = 1;
    tick(0, 12'h003, 0, 0, 0, 0, 0, "start");
    start = 0;
    tick(0, 12'h004, 0, 0, 0, 0, 0, "seq_after_start");
    tick(0, 12'h005, 0, 0, 0, 0, 0, "seq_after_start");

    // 2. conditional jump
    ins(1, JMPC, 12'h000, 8'h2A, 8'h00);
    tick(0, 12'h02A, 1, 0, 0, 0, 0, "jmpc_taken");
    ins(1, JMPC, 12'h000, 8'h2A, 8'h01);
    tick(0, 12'h02B, 0, 0, 0, 0, 0, "jmpc_not_taken");

    // 3. call/return nesting, overflow, underflow
    ins(1, JMPD, 12'h010, 8'h00, 8'h00);
    tick(0, 12'h010, 1, 0, 0, 0, 0, "jmpd");
    for (int k = 1; k <= 8; k++) begin
      ins(1, CALL, 12'h000, 8'(16 * (k + 1)), 8'h00);
      tick(0, 12'(16 * (k + 1)), 1, 0, k, 0, 0, "call");
    end
    ins(1, CALL, 12'h000, 8'hAA, 8'h00);
    tick(0, 12'h091, 0, 0, 8, 1, 0, "call_overflow");
    ins(1, RET, 12'h000, 8'h00, 8'h00);
    for (int k = 8; k >= 1; k--) tick(0, 12'(16 * k + 1), 1, 0, k - 1, 1, 0, "ret");
    tick(0, 12'h012, 0, 0, 0, 1, 1, "ret_underflow");
    err_clr = 1;
    ins(1, NOP, 12'h000, 8'h00, 8'h00);
    tick(0, 12'h013, 0, 0, 0, 0, 0, "err_clr");
    err_clr = 0;

    // 4. MEMW hold with MEMW_WAIT=1, including a dropped inst_valid
    ins(1, JMPD, 12'h040, 8'h00, 8'h00);
    tick(0, 12'h040, 1, 0, 0, 0, 0, "jmpd_40");
    ins(1, MEMW, 12'h000, 8'h00, 8'h00);
    tick(0, 12'h040, 0, 1, 0, 0, 0, "memw_hold");
    tick(0, 12'h041, 0, 0, 0, 0, 0, "memw_done");
    tick(0, 12'h041, 0, 1, 0, 0, 0, "memw2_hold");
    ins(0, MEMW, 12'h000, 8'h00, 8'h00);
    tick(0, 12'h041, 0, 1, 0, 0, 0, "memw2_idle");
    ins(1, MEMW, 12'h000, 8'h00, 8'h00);
    tick(0, 12'h042, 0, 0, 0, 0, 0, "memw2_done");

    // 4b. MEMW_WAIT=3 instance
    ins(0, JMPD, 12'h040, 8'h00, 8'h00);
    iv_b = 1;
    tick(1, 12'h040, 1, 0, 0, 0, 0, "b_jmpd_40");
    opcode = MEMW;
    tick(1, 12'h040, 0, 1, 0, 0, 0, "b_memw1");
    tick(1, 12'h040, 0, 1, 0, 0, 0, "b_memw2");
    iv_b = 0;
    tick(1, 12'h040, 0, 1, 0, 0, 0, "b_memw_idle");
    iv_b = 1;
    tick(1, 12'h040, 0, 1, 0, 0, 0, "b_memw3");
    tick(1, 12'h041, 0, 0, 0, 0, 0, "b_memw_done");
    iv_b = 0;

    // 5. wrap, JMPD, CALL pushing 0x000
    ins(1, JMPD, 12'hFFF, 8'h00, 8'h00);
    tick(0, 12'hFFF, 1, 0, 0, 0, 0, "jmpd_fff");
    ins(1, NOP, 12'h000, 8'h00, 8'h00);
    tick(0, 12'h000, 0, 0, 0, 0, 0, "wrap");
    ins(1, JMPD, 12'hFFF, 8'h00, 8'h00);
    tick(0, 12'hFFF, 1, 0, 0, 0, 0, "jmpd_fff2");
    ins(1, CALL, 12'h000, 8'h05, 8'h00);
    tick(0, 12'h005, 1, 0, 1, 0, 0, "call_wrap");
    ins(1, RET, 12'h000, 8'h00, 8'h00);
    tick(0, 12'h000, 1, 0, 0, 0, 0, "ret_wrap");

    // 6. priority, mid-MEMW reset, err_clr vs new overflow
    ins(1, JMPD, 12'h077, 8'h00, 8'h00);
    tick(0, 12'h077, 1, 0, 0, 0, 0, "jmpd_77");
    rst = 1; start = 1;
    tick(0, 12'h000, 0, 0, 0, 0, 0, "rst_over_start");
    rst = 0; start = 0;
    ins(1, JMPD, 12'h040, 8'h00, 8'h00);
    tick(0, 12'h040, 1, 0, 0, 0, 0, "jmpd_40b");
    ins(1, MEMW, 12'h000, 8'h00, 8'h00);
    tick(0, 12'h040, 0, 1, 0, 0, 0, "memw_before_rst");
    rst = 1;
    tick(0, 12'h000, 0, 0, 0, 0, 0, "rst_mid_memw");
    rst = 0;
    tick(0, 12'h000, 0, 1, 0, 0, 0, "memw_after_rst");
    tick(0, 12'h001, 0, 0, 0, 0, 0, "memw_after_rst_done");
    ins(1, CALL, 12'h000, 8'h10, 8'h00);
    for (int k = 1; k <= 8; k++) tick(0, 12'h010, 1, 0, k, 0, 0, "fill");
    err_clr = 1;
    tick(0, 12'h011, 0, 0, 8, 1, 0, "set_beats_clr");
    ins(1, NOP, 12'h000, 8'h00, 8'h00);
    tick(0, 12'h012, 0, 0, 8, 0, 0, "clr_after");
    err_clr = 0;

    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-address unit for the execute stage.
- Owns the program counter, a hardware call/return stack, conditional and direct jumps, and the memory-write hold cycles.
- Generalises address resolution: configurable address/data width, stack depth and write-hold length; adds stack overflow/underflow detection, an instruction-valid qualifier and a taken-branch indicator.
- Output `pc` drives the instruction BRAM address.

Parameters:
- ADDR_W, 12: program counter / stack entry width.
- DATA_W, 8: register-file word width. Must satisfy DATA_W <= ADDR_W.
- STACK_DEPTH, 8: number of return-address entries. Must be >= 2.
- START_ADDR, 3: PC value loaded by `start`.
- RESET_ADDR, 0: PC value loaded by `rst`.
- MEMW_WAIT, 1: extra cycles PC holds on a MEMW.

Ports:
- clk, input, 1: clock; all state updates on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: synchronous load of START_ADDR.
- inst_valid, input, 1: opcode/operands valid this cycle.
- opcode, input, 4: instruction bits [15:12].
- imm, input, ADDR_W: direct jump target, instruction bits [ADDR_W-1:0].
- reg_target, input, DATA_W: register-file read of the target register.
- reg_cond, input, DATA_W: register-file read of the condition register.
- err_clr, input, 1: clears the sticky error flags.
- pc, output, ADDR_W: current program counter.
- taken, output, 1: last update loaded a non-sequential target.
- busy, output, 1: PC held for a MEMW.
- depth, output, $clog2(STACK_DEPTH+1): stack occupancy.
- overflow_err, output, 1: sticky; CALL attempted with stack full.
- underflow_err, output, 1: sticky; RET attempted with stack empty.

Behaviour:
- All outputs are registered.
- `seq` = pc+1, modulo 2^ADDR_W (0xFFF wraps to 0x000 at the default width).
- `reg_target` is zero-extended to ADDR_W.

Priority each cycle: rst > start > (inst_valid decode) > hold.

rst:
- pc=RESET_ADDR; depth=0; taken=0; busy=0; wait counter=0.
- overflow_err=0; underflow_err=0.
- Stack contents are don't-care.
- Reset mid-MEMW or mid-anything aborts the operation; no other state survives.

start:
- pc=START_ADDR; depth=0; wait counter=0; taken=0; busy=0.
- Error flags are unchanged.

err_clr:
- Clears both flags unless the same cycle sets one; set wins.
- Ignored under rst, which already clears.

inst_valid=0:
- pc, depth and wait counter hold; taken=0; busy holds.

Decode when inst_valid=1:
- 1000 JMPC: if reg_cond==0, pc=reg_target and taken=1; else pc=seq and taken=0.
- 1001 JMPD: pc=imm; taken=1.
- 1010 CALL:
  - If depth<STACK_DEPTH: stack[depth]=seq; depth+1; pc=reg_target; taken=1.
  - If full: no push, no jump; pc=seq; overflow_err=1; taken=0.
- 1011 RET:
  - If depth>0: pc=stack[depth-1]; depth-1; taken=1.
  - If empty: pc=seq; underflow_err=1; taken=0.
- 1101 MEMW:
  - If wait counter < MEMW_WAIT: pc holds; counter+1; busy=1.
  - Otherwise: pc=seq; counter=0; busy=0.
  - MEMW_WAIT=0 advances immediately (no hold).
  - Default MEMW_WAIT=1 gives exactly two cycles per MEMW.
- Any other opcode: pc=seq; taken=0.
- Any non-MEMW valid opcode clears the wait counter and busy.

Stack behaviour:
- LIFO.
- Return addresses are full ADDR_W (no truncation).
- Only one push or pop per cycle.
- CALL then RET restores exactly the pushed seq value, including a wrapped 0x000.

Latency:
- One cycle from decode to the pc update.
- `taken` and `busy` are valid in the same cycle as the new pc.

Test Plan:
1. Reset and sequential run: rst high for 2 clocks, then 5 valid NOPs (opcode 0000) -> pc 0,1,2,3,4,5; start pulse -> pc=3, depth=0; taken=0 throughout.
2. Conditional jump: JMPC with reg_cond=0, reg_target=0x2A at pc=5 -> pc=0x02A, taken=1. Same instruction with reg_cond=0x01 at pc=0x2A -> pc=0x02B, taken=0.
3. Call/return nesting: depth=8 calls from pc=0x10, 0x20, ..., each reg_target=(pc+0x10) -> depth=8. 9th CALL -> overflow_err=1, depth stays 8, pc=seq. Then 8 RETs -> pc pops 0x081, 0x071, ..., 0x011, depth=0. 9th RET -> underflow_err=1, pc=seq.
4. MEMW hold: MEMW at pc=0x040 with MEMW_WAIT=1 -> pc 0x040 for 2 cycles (busy=1 then 0), then 0x041. With MEMW_WAIT=3 -> 4 cycles at 0x040. inst_valid dropped mid-hold -> counter frozen, resumes.
5. Wrap and JMPD: JMPD imm=0xFFF -> pc=0xFFF; CALL reg_target=0x05 -> pushed 0x000; RET -> pc=0x000.
6. Priority and mid-operation reset: rst and start together -> pc=RESET_ADDR. rst during MEMW hold -> pc=0, busy=0. err_clr in the same cycle as a new overflow -> overflow_err stays 1.
